// File: rtl/dport_arbiter_pkg.sv
// Shared types and constants for the two-master data-port arbiter.
package dport_arbiter_pkg;

   localparam int TAG_W = 11;

   typedef logic owner_t;

   localparam owner_t OWNER_CORE = 1'b0;
   localparam owner_t OWNER_DBG  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/dport_owner_fifo.sv
// In-order record of which master owns each outstanding downstream request.
module dport_owner_fifo
   import dport_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   push_i,
   input  owner_t push_id_i,
   input  logic   pop_i,
   output owner_t head_id_o,
   output logic   empty_o,
   output logic   full_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   owner_t [DEPTH-1:0] slots;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
   endfunction

   assign empty_o   = (count == '0);
   assign full_o    = (count == CNT_FULL);
   assign head_id_o = slots[rd_ptr];
   assign do_push   = push_i & ~full_o;
   assign do_pop    = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            slots[wr_ptr] <= push_id_i;
            wr_ptr        <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dport_arbiter.sv
// Arbitrates core (m0) and debug (m1) masters onto one downstream data port,
// routing in-order responses back to whichever master issued each request.
//
// state    | meaning
// ST_IDLE  | free to pick a new grant each cycle
// ST_LOCK0 | m0 granted but not yet accepted; request held stable
// ST_LOCK1 | m1 granted but not yet accepted; request held stable
module dport_arbiter
   import dport_arbiter_pkg::*;
#(
   parameter int OUTSTANDING  = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic [31:0]      m0_addr_i,
   input  logic [31:0]      m0_data_wr_i,
   input  logic             m0_rd_i,
   input  logic [3:0]       m0_wr_i,
   input  logic [TAG_W-1:0] m0_req_tag_i,
   output logic             m0_accept_o,
   output logic             m0_ack_o,
   output logic [31:0]      m0_data_rd_o,
   output logic             m0_error_o,
   output logic [TAG_W-1:0] m0_resp_tag_o,

   input  logic [31:0]      m1_addr_i,
   input  logic [31:0]      m1_data_wr_i,
   input  logic             m1_rd_i,
   input  logic [3:0]       m1_wr_i,
   input  logic [TAG_W-1:0] m1_req_tag_i,
   output logic             m1_accept_o,
   output logic             m1_ack_o,
   output logic [31:0]      m1_data_rd_o,
   output logic             m1_error_o,
   output logic [TAG_W-1:0] m1_resp_tag_o,

   output logic [31:0]      mem_d_addr_o,
   output logic [31:0]      mem_d_data_wr_o,
   output logic             mem_d_rd_o,
   output logic [3:0]       mem_d_wr_o,
   output logic [TAG_W-1:0] mem_d_req_tag_o,
   input  logic             mem_d_accept_i,
   input  logic             mem_d_ack_i,
   input  logic             mem_d_error_i,
   input  logic [31:0]      mem_d_data_rd_i,
   input  logic [TAG_W-1:0] mem_d_resp_tag_i,

   output logic             unexpected_ack_o
);

   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_t state;
   arb_state_t state_nx;

   logic          pend0;
   logic          pend1;
   logic          gnt0;
   logic          gnt1;
   logic          can_issue;
   logic          acc0;
   logic          acc1;
   logic          block_req;
   logic          ack_valid;
   logic          fifo_full;
   logic          fifo_empty;
   owner_t        fifo_head;
   logic [SW-1:0] starve_cnt;

   assign pend0 = m0_rd_i | (|m0_wr_i);
   assign pend1 = m1_rd_i | (|m1_wr_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (gnt0 && !acc0)      state_nx = ST_LOCK0;
            else if (gnt1 && !acc1) state_nx = ST_LOCK1;
            else                    state_nx = ST_IDLE;
         end
         // A master that withdraws while locked releases the port.
         ST_LOCK0: if (acc0 || !pend0) state_nx = ST_IDLE;
         ST_LOCK1: if (acc1 || !pend1) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (pend1 && starve_cnt == STARVE_MAX) gnt1 = 1'b1;
            else if (pend0)                        gnt0 = 1'b1;
            else if (pend1)                        gnt1 = 1'b1;
         end
         ST_LOCK0: gnt0 = 1'b1;
         ST_LOCK1: gnt1 = 1'b1;
         default: begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
         end
      endcase
   end

   assign block_req = fifo_full | rst_i;
   assign can_issue = mem_d_accept_i & ~block_req;
   assign acc0      = gnt0 & pend0 & can_issue;
   assign acc1      = gnt1 & pend1 & can_issue;

   assign m0_accept_o = acc0;
   assign m1_accept_o = acc1;

   assign mem_d_addr_o    = gnt1 ? m1_addr_i    : m0_addr_i;
   assign mem_d_data_wr_o = gnt1 ? m1_data_wr_i : m0_data_wr_i;
   assign mem_d_req_tag_o = gnt1 ? m1_req_tag_i : m0_req_tag_i;
   assign mem_d_rd_o      = ~block_req & ((gnt0 & m0_rd_i) | (gnt1 & m1_rd_i));
   assign mem_d_wr_o      = {4{~block_req}} & (({4{gnt0}} & m0_wr_i) | ({4{gnt1}} & m1_wr_i));

   always_ff @(posedge clk_i) begin
      if (rst_i)                 starve_cnt <= '0;
      else if (acc1 || !pend1)   starve_cnt <= '0;
      else if (acc0 && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
   end

   dport_owner_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_owner_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (acc0 | acc1),
      .push_id_i (acc1 ? OWNER_DBG : OWNER_CORE),
      .pop_i     (ack_valid),
      .head_id_o (fifo_head),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   assign ack_valid = mem_d_ack_i & ~fifo_empty & ~rst_i;

   assign m0_ack_o      = ack_valid & (fifo_head == OWNER_CORE);
   assign m1_ack_o      = ack_valid & (fifo_head == OWNER_DBG);
   assign m0_data_rd_o  = mem_d_data_rd_i;
   assign m1_data_rd_o  = mem_d_data_rd_i;
   assign m0_error_o    = mem_d_error_i;
   assign m1_error_o    = mem_d_error_i;
   assign m0_resp_tag_o = mem_d_resp_tag_i;
   assign m1_resp_tag_o = mem_d_resp_tag_i;

   always_ff @(posedge clk_i) begin
      if (rst_i)                          unexpected_ack_o <= 1'b0;
      else if (mem_d_ack_i && fifo_empty) unexpected_ack_o <= 1'b1;
   end

endmodule
